// File: rtl/table_bg_renderer.sv
// table_bg_renderer: billiard-table background layer with palette shadowing and felt flash; 2-cycle pipeline.
// Optional TABLE_BG_DITHER_EN dithers the green field of felt pixels on a checkerboard.
module table_bg_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RAIL_W = 35,
  parameter int POCKET_R = 12,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_CYCLES = 3,
  parameter logic [7:0] FLASH_RGB = 8'hE0
) (
  input  logic clk,
  input  logic reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic startOfFrame,
  input  logic cfg_valid,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] cfg_data,
  output logic cfg_ready,
  input  logic flash_req,
  output logic flash_busy,
  output logic [7:0] BG_RGB,
  output logic bordersDrawReq,
  output logic pocketDrawReq
);
  localparam logic [10:0] XM = 11'(H_ACTIVE - 1);
  localparam logic [10:0] YM = 11'(V_ACTIVE - 1);
  localparam logic [10:0] RW = 11'(RAIL_W);
  localparam logic [10:0] XC = 11'(H_ACTIVE / 2);
  localparam logic [10:0] XR = 11'(H_ACTIVE - 1 - RAIL_W);
  localparam logic [10:0] YB = 11'(V_ACTIVE - 1 - RAIL_W);
  localparam logic signed [11:0] LIM = 12'(POCKET_R + 1);
  localparam logic [21:0] R2 = 22'(POCKET_R * POCKET_R);
  localparam logic [31:0] PAL_DEF = 32'h0000_6558;
  localparam logic [7:0] FF1 = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] PC1 = 8'(FLASH_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ON, OFF} st_t;
  st_t st, st_n;
  logic [7:0] fc, fc_n, pc, pc_n;
  logic [3:0][7:0] sh, act;
  logic pending;
  logic [21:0] sx0, sx1, sx2, sy0, sy1;
  logic off, pk, cu, ra, off1, pk1, cu1, ra1;
  logic [7:0] felt_base, felt_c;
  // Clipping the delta keeps the square small; anything past the window is already outside the circle.
  function automatic logic [21:0] sq(input logic [10:0] a, input logic [10:0] c);
    logic signed [11:0] d;
    logic signed [21:0] e;
    d = $signed({1'b0, a}) - $signed({1'b0, c});
    d = d > LIM ? LIM : (d < -LIM ? -LIM : d);
    e = 22'(d);
    return 22'(e * e);
  endfunction
  assign sx0 = sq(pixelX, RW);
  assign sx1 = sq(pixelX, XC);
  assign sx2 = sq(pixelX, XR);
  assign sy0 = sq(pixelY, RW);
  assign sy1 = sq(pixelY, YB);
  assign off = pixelX >= XM || pixelY >= YM || pixelX == 11'd0 || pixelY == 11'd0;
  assign pk = sx0 + sy0 <= R2 || sx1 + sy0 <= R2 || sx2 + sy0 <= R2 ||
              sx0 + sy1 <= R2 || sx1 + sy1 <= R2 || sx2 + sy1 <= R2;
  assign cu = pixelX == RW || pixelY == RW || pixelX == XR || pixelY == YB;
  assign ra = pixelX < RW || pixelY < RW || pixelX > XR || pixelY > YB;
  always_ff @(posedge clk) begin
    if (reset) begin
      off1 <= 1'b1;
      pk1 <= 1'b0;
      cu1 <= 1'b0;
      ra1 <= 1'b0;
    end else begin
      off1 <= off;
      pk1 <= pk;
      cu1 <= cu;
      ra1 <= ra;
    end
  end
  // A commit uses the shadow as it stood before any same-cycle write, which then stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= PAL_DEF;
      act <= PAL_DEF;
      pending <= 1'b0;
    end else begin
      if (startOfFrame && pending) begin
        act <= sh;
        pending <= 1'b0;
      end
      if (cfg_valid && cfg_ready) begin
        sh[cfg_sel] <= cfg_data;
        pending <= 1'b1;
      end
    end
  end
  assign cfg_ready = ~pending;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      fc <= '0;
      pc <= '0;
      flash_busy <= 1'b0;
    end else begin
      st <= st_n;
      fc <= fc_n;
      pc <= pc_n;
      flash_busy <= st_n != IDLE;
    end
  end
  always_comb begin
    st_n = st;
    fc_n = fc;
    pc_n = pc;
    if (st == IDLE) begin
      if (flash_req) begin
        st_n = ON;
        fc_n = '0;
        pc_n = '0;
      end
    end else if (startOfFrame) begin
      fc_n = fc == FF1 ? '0 : fc + 8'd1;
      if (fc == FF1) begin
        st_n = st == ON ? OFF : (pc == PC1 ? IDLE : ON);
        pc_n = st == OFF ? pc + 8'd1 : pc;
      end
    end
  end
  assign felt_base = st == ON ? FLASH_RGB : act[0];
`ifdef TABLE_BG_DITHER_EN
  logic d1;
  always_ff @(posedge clk) begin
    if (reset) d1 <= 1'b0;
    else d1 <= pixelX[0] ^ pixelY[0];
  end
  assign felt_c = (d1 && felt_base[4:2] != 3'd0) ? felt_base - 8'h04 : felt_base;
`else
  assign felt_c = felt_base;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      BG_RGB <= 8'h00;
      bordersDrawReq <= 1'b0;
      pocketDrawReq <= 1'b0;
    end else begin
      BG_RGB <= off1 ? 8'h00 : pk1 ? act[3] : cu1 ? act[2] : ra1 ? act[1] : felt_c;
      pocketDrawReq <= !off1 && pk1;
      bordersDrawReq <= !off1 && !pk1 && cu1;
    end
  end
endmodule

// File: tb/tb_table_bg_renderer.sv
// tb_table_bg_renderer: randomized check of table_bg_renderer against a region/palette/flash reference model.
module tb_table_bg_renderer;
  localparam int W = 640, H = 480, RW = 35, PR = 12, FF = 8, FC = 3, FT = 2 * FF * FC;
  logic clk = 1'b0, reset = 1'b1;
  logic [10:0] px = 11'd320, py = 11'd240;
  logic sof = 1'b0, cv = 1'b0, freq = 1'b0;
  logic [1:0] cs = 2'd0;
  logic [7:0] cd = 8'd0;
  logic cr, fb, br, pr;
  logic [7:0] bg;
  int checks = 0, failures = 0;
  logic [7:0] m_sh[4], m_act[4];
  bit m_pend;
  int m_ff;
  always #5 clk = ~clk;
  table_bg_renderer dut (
    .clk(clk), .reset(reset), .pixelX(px), .pixelY(py), .startOfFrame(sof),
    .cfg_valid(cv), .cfg_sel(cs), .cfg_data(cd), .cfg_ready(cr),
    .flash_req(freq), .flash_busy(fb), .BG_RGB(bg),
    .bordersDrawReq(br), .pocketDrawReq(pr)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // 0 black, 1 pocket, 2 cushion line, 3 rail, 4 felt
  function automatic int region(input int x, input int y);
    int cx[3];
    int cy[2];
    cx = '{RW, W / 2, W - 1 - RW};
    cy = '{RW, H - 1 - RW};
    if (x > W - 1 || y > H - 1 || x == 0 || y == 0 || x == W - 1 || y == H - 1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        if ((x - cx[i]) * (x - cx[i]) + (y - cy[j]) * (y - cy[j]) <= PR * PR) return 1;
    if (x == RW || y == RW || x == W - 1 - RW || y == H - 1 - RW) return 2;
    if (x < RW || y < RW || x > W - 1 - RW || y > H - 1 - RW) return 3;
    return 4;
  endfunction
  function automatic logic [7:0] exp_bg(input int x, input int y);
    logic [7:0] f;
    int r;
    r = region(x, y);
    if (r == 0) return 8'h00;
    if (r == 1) return m_act[3];
    if (r == 2) return m_act[2];
    if (r == 3) return m_act[1];
    f = (m_ff < FT && (m_ff / FF) % 2 == 0) ? 8'hE0 : m_act[0];
`ifdef TABLE_BG_DITHER_EN
    if (((x ^ y) & 1) == 1 && f[4:2] != 3'd0) f = f - 8'h04;
`endif
    return f;
  endfunction
  task automatic model_reset();
    m_sh = '{8'h58, 8'h65, 8'h00, 8'h00};
    m_act = '{8'h58, 8'h65, 8'h00, 8'h00};
    m_pend = 1'b0;
    m_ff = FT;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_sof();
    if (m_pend) begin
      m_act = m_sh;
      m_pend = 1'b0;
    end
    if (m_ff < FT) m_ff++;
  endtask
  task automatic check_px(input int x, input int y);
    int r;
    px = 11'(x);
    py = 11'(y);
    repeat (3) step();
    r = region(x, y);
    check($sformatf("bg(%0d,%0d)", x, y), bg, exp_bg(x, y));
    check($sformatf("pocket(%0d,%0d)", x, y), {7'd0, pr}, {7'd0, r == 1});
    check($sformatf("border(%0d,%0d)", x, y), {7'd0, br}, {7'd0, r == 2});
  endtask
  task automatic do_sof();
    sof = 1'b1;
    step();
    sof = 1'b0;
    model_sof();
  endtask
  task automatic do_write(input logic [1:0] sel, input logic [7:0] data, input bit with_sof);
    bit acc;
    acc = !m_pend;
    cv = 1'b1;
    cs = sel;
    cd = data;
    sof = with_sof;
    step();
    cv = 1'b0;
    sof = 1'b0;
    if (with_sof) model_sof();
    if (acc) begin
      m_sh[sel] = data;
      m_pend = 1'b1;
    end
    check("cfg_ready", {7'd0, cr}, {7'd0, !m_pend});
  endtask
  task automatic do_flash();
    freq = 1'b1;
    step();
    freq = 1'b0;
    if (m_ff >= FT) m_ff = 0;
  endtask
  task automatic rand_px();
    int m, x, y;
    int lv[11];
    lv = '{0, 1, 34, 35, 36, 319, 320, 603, 604, 638, 639};
    m = $urandom_range(0, 3);
    if (m == 0) begin
      x = $urandom_range(0, 700);
      y = $urandom_range(0, 520);
    end else if (m == 1) begin
      x = (($urandom_range(0, 2) == 0) ? RW : ($urandom_range(0, 1) == 0 ? W / 2 : W - 1 - RW)) + $urandom_range(0, 30) - 15;
      y = (($urandom_range(0, 1) == 0) ? RW : H - 1 - RW) + $urandom_range(0, 30) - 15;
    end else if (m == 2) begin
      x = lv[$urandom_range(0, 10)];
      y = $urandom_range(0, 1) == 0 ? lv[$urandom_range(0, 4)] : $urandom_range(440, 480);
    end else begin
      x = $urandom_range(0, 2047);
      y = $urandom_range(0, 2047);
    end
    check_px(x, y);
  endtask
  initial begin
    int tx[5];
    int ty[5];
    tx = '{0, 10, 200, 40, 320};
    ty = '{100, 200, 35, 40, 35};
    model_reset();
    repeat (2) step();
    check("rst_bg", bg, 8'h00);
    check("rst_border", {7'd0, br}, 8'd0);
    check("rst_pocket", {7'd0, pr}, 8'd0);
    check("rst_ready", {7'd0, cr}, 8'd1);
    check("rst_busy", {7'd0, fb}, 8'd0);
    reset = 1'b0;
    check_px(320, 240);
    check_px(321, 240);
    for (int i = 0; i < 5; i++) check_px(tx[i], ty[i]);
    do_write(2'd0, 8'h1C, 1'b0);
    check_px(320, 240);
    do_sof();
    step();
    check("ready_after_commit", {7'd0, cr}, 8'd1);
    check_px(320, 240);
    do_write(2'd1, 8'h03, 1'b1);
    check_px(10, 200);
    do_sof();
    check_px(10, 200);
    px = 11'd320;
    py = 11'd240;
    do_flash();
    repeat (3) step();
    check("flash_f0", bg, exp_bg(320, 240));
    check("busy_f0", {7'd0, fb}, 8'd1);
    for (int i = 0; i < FT; i++) begin
      if (i == 10) do_flash();
      do_sof();
      repeat (3) step();
      check($sformatf("flash_f%0d", i + 1), bg, exp_bg(320, 240));
      check($sformatf("busy_f%0d", i + 1), {7'd0, fb}, {7'd0, m_ff < FT});
    end
    do_flash();
    do_write(2'd0, 8'h03, 1'b0);
    reset = 1'b1;
    step();
    check("rst2_busy", {7'd0, fb}, 8'd0);
    check("rst2_ready", {7'd0, cr}, 8'd1);
    reset = 1'b0;
    model_reset();
    check_px(320, 240);
    check_px(10, 200);
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: do_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        1: do_sof();
        2: do_flash();
        3: repeat (3) do_sof();
        default: step();
      endcase
      repeat (3) rand_px();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/table_bg_renderer.md
Name: table_bg_renderer

Overview:
- Parametrised successor to the billiard-table background painter.
- Per pixel, classifies the VGA coordinate into one of five regions: frame line, pocket, cushion line, rail or felt.
- Outputs an RGB332 colour and draw requests through a fixed 2-cycle pipeline.
- Adds a frame-synchronised palette update port and a frame-counted felt "flash" animation FSM for foul/score feedback; feeds the VGA object mux as the lowest-priority layer.

Parameters:
- H_ACTIVE, 640, visible width in pixels; X_MAX = H_ACTIVE-1
- V_ACTIVE, 480, visible height in pixels; Y_MAX = V_ACTIVE-1
- RAIL_W, 35, cushion line offset from screen edge
- POCKET_R, 12, pocket radius in pixels (circle test dx*dx+dy*dy <= POCKET_R*POCKET_R)
- FLASH_FRAMES, 8, frames per flash half-period
- FLASH_CYCLES, 3, number of ON/OFF pairs per flash request
- FLASH_RGB, 8'hE0, felt colour during flash ON phase

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- startOfFrame  in  1  one-cycle pulse at frame start
- cfg_valid  in  1  palette write request
- cfg_sel  in  2  0=felt, 1=rail, 2=line, 3=pocket
- cfg_data  in  8  RGB332 colour
- cfg_ready  out  1  palette write accepted when valid&&ready
- flash_req  in  1  start flash sequence (pulse)
- flash_busy  out  1  flash FSM not IDLE
- BG_RGB  out  8  background colour, RGB332
- bordersDrawReq  out  1  pixel is on cushion line
- pocketDrawReq  out  1  pixel is inside a pocket

Behaviour:
- Reset:
  - BG_RGB=8'h00; bordersDrawReq=0; pocketDrawReq=0; flash_busy=0; cfg_ready=1.
  - FSM=IDLE; counters 0.
  - Active and shadow palette: felt=8'h58, rail=8'h65, line=8'h00, pocket=8'h00.
  - Reset mid-frame or mid-flash discards all state the same cycle; nothing is pending afterwards.
- Pipeline, fixed latency 2: pixel presented at cycle N appears on outputs at N+2.
  - Stage 1 registers the region flags, with each pocket delta clipped to a window of ±(POCKET_R+1) and squared into 22 bits.
  - Stage 2 registers colour and requests.
- Region priority, highest first:
  1. Frame line: X==0 | Y==0 | X==X_MAX | Y==Y_MAX -> 8'h00, no requests.
  2. Pocket: inside any of 6 circles centred (RAIL_W,RAIL_W), (H_ACTIVE/2,RAIL_W), (X_MAX-RAIL_W,RAIL_W), (RAIL_W,Y_MAX-RAIL_W), (H_ACTIVE/2,Y_MAX-RAIL_W), (X_MAX-RAIL_W,Y_MAX-RAIL_W) -> pocket colour, pocketDrawReq=1.
  3. Cushion line: X==RAIL_W | Y==RAIL_W | X==X_MAX-RAIL_W | Y==Y_MAX-RAIL_W -> line colour, bordersDrawReq=1.
  4. Rail: X<RAIL_W | Y<RAIL_W | X>X_MAX-RAIL_W | Y>Y_MAX-RAIL_W -> rail colour.
  5. Felt: all other pixels -> felt colour, or FLASH_RGB in the ON phase.
- Coordinates outside the visible area (X>X_MAX or Y>Y_MAX) -> 8'h00, no requests.
- Palette handshake:
  - A write occurs on cfg_valid&&cfg_ready and goes to the shadow entry cfg_sel; it also sets pending and drops cfg_ready.
  - On startOfFrame with pending set, all shadow entries copy to active, pending clears, and cfg_ready rises the next cycle.
  - A write and startOfFrame in the same cycle: the commit uses the pre-write shadow, and the new write stays pending until the next frame.
  - Active colours never change mid-frame.
- Flash FSM, states IDLE, ON, OFF:
  - IDLE + flash_req -> ON; frame_cnt=0; pair_cnt=0.
  - Each startOfFrame in ON/OFF increments frame_cnt.
  - At frame_cnt==FLASH_FRAMES-1: frame_cnt=0 and the state toggles. OFF->ON increments pair_cnt. OFF with pair_cnt==FLASH_CYCLES-1 -> IDLE.
  - flash_req while busy is ignored (no restart, no queue).
  - flash_busy = (state!=IDLE), registered.

Optional Feature:
- TABLE_BG_DITHER_EN defined: felt pixels with pixelX[0]^pixelY[0]==1 have their green field decremented by 1, saturating at 0. This applies to both the palette felt colour and FLASH_RGB. Latency stays at 2.
- Undefined: felt is uniform; no extra logic.

Test Plan:
- After reset, pixel (320,240) held -> at N+2 BG_RGB=8'h58, both requests 0; cfg_ready=1, flash_busy=0.
- Pixels (0,100), (10,200), (200,35), (40,40), (320,35) -> 8'h00; 8'h65; 8'h00 with bordersDrawReq=1; 8'h00 with pocketDrawReq=1; 8'h00 with pocketDrawReq=1.
- Write sel=0 data=8'h1C mid-frame -> cfg_ready=0 and felt stays 8'h58 until startOfFrame. The next frame's felt=8'h1C and cfg_ready=1. A write and startOfFrame in the same cycle -> applied one frame later.
- flash_req, then 48 startOfFrame pulses (defaults) -> felt is 8'hE0 for frames 0-7, 16-23 and 32-39, 8'h58 otherwise. flash_busy drops after the 48th pulse. A second flash_req at frame 10 has no effect.
- Assert reset during the flash ON phase with a write pending -> the next cycle shows FSM IDLE, flash_busy=0, cfg_ready=1, and the palette back to defaults.
- With TABLE_BG_DITHER_EN: pixel (321,240) -> 8'h54; (320,240) -> 8'h58.
